mux_dec_sweep_ctrl: RTL and testbench

Self-checking sweep controller for the 16:1 mux / dual 2:4 decoder datapath pair (registered outputs o1 and o2). On start it:
- resets the datapath;
- drives all 256 input combinations of a..h, one per cycle;
- compares the registered o1/o2 pair one cycle after each vector;
- reports pass/fail, a mismatch count and the first failing vector.

It sits beside the datapath as its on-chip stimulus and checking sequencer.

---
 rtl/mux_dec_pkg.sv | 23 ++
 rtl/sweep_checker.sv | 64 ++++++
 rtl/mux_dec_sweep_ctrl.sv | 117 +++++++++++
 tb/tb_mux_dec_sweep_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_dec_pkg.sv
// Shared types and constants for the mux/decoder sweep controller.
// Vector bit positions follow the datapath input order a..h.
package mux_dec_pkg;
    localparam int VEC_W   = 8;
    localparam int NUM_VEC = 256;

    localparam int A_IDX = 0;
    localparam int B_IDX = 1;
    localparam int C_IDX = 2;
    localparam int D_IDX = 3;
    localparam int E_IDX = 4;
    localparam int F_IDX = 5;
    localparam int G_IDX = 6;
    localparam int H_IDX = 7;

    typedef enum logic [2:0] {
        IDLE,
        DUT_RST,
        SWEEP,
        DRAIN,
        DONE
    } state_t;
endpackage

// File: rtl/sweep_checker.sv
// Compare/log stage: checks o1 against o2 one cycle after each swept vector.
// Latency 1 cycle from vector to compare; no backpressure, abort freezes results.
module sweep_checker
    import mux_dec_pkg::*;
#(
    parameter int ERR_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_sweep,
    input  logic             i_clr,
    input  logic             i_abort,
    input  logic [VEC_W-1:0] i_vec,
    input  logic             i_o1,
    input  logic             i_o2,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic             o_first_err_valid,
    output logic [VEC_W-1:0] o_first_err_vec,
    output logic             o_clean
);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic             r_cmp_vld;
    logic [VEC_W-1:0] r_vec_d;
    logic [ERR_W-1:0] r_err_cnt;
    logic             r_first_err_valid;
    logic [VEC_W-1:0] r_first_err_vec;
    logic             w_mis;

    assign w_mis = r_cmp_vld & (i_o1 ^ i_o2) & ~i_abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cmp_vld         <= 1'b0;
            r_vec_d           <= '0;
            r_err_cnt         <= '0;
            r_first_err_valid <= 1'b0;
            r_first_err_vec   <= '0;
        end else begin
            r_cmp_vld <= i_sweep & ~i_abort;
            r_vec_d   <= i_vec;
            if (i_clr) begin
                r_err_cnt         <= '0;
                r_first_err_valid <= 1'b0;
                r_first_err_vec   <= '0;
            end else if (w_mis) begin
                if (r_err_cnt != ERR_MAX) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
                if (!r_first_err_valid) begin
                    r_first_err_valid <= 1'b1;
                    r_first_err_vec   <= r_vec_d;
                end
            end
        end
    end

    // Lets the FSM register pass in the same edge as the final compare lands.
    assign o_clean = (r_err_cnt == '0) & ~w_mis;

    assign o_err_cnt         = r_err_cnt;
    assign o_first_err_valid = r_first_err_valid;
    assign o_first_err_vec   = r_first_err_vec;
endmodule

// File: rtl/mux_dec_sweep_ctrl.sv
// Sweep controller: resets the datapath, drives all 256 vectors, reports pass/fail.
// Done arrives RST_CYCLES+257 cycles after start; start ignored while busy, abort wins.
module mux_dec_sweep_ctrl
    import mux_dec_pkg::*;
#(
    parameter int RST_CYCLES = 2,
    parameter int ERR_W      = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             dut_rst,
    output logic [VEC_W-1:0] vec,
    input  logic             o1,
    input  logic             o2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             first_err_valid,
    output logic [VEC_W-1:0] first_err_vec
);
    localparam logic [3:0]       RST_LAST = 4'(RST_CYCLES);
    localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VEC - 1);

    state_t           r_state;
    logic [3:0]       r_rst_cnt;
    logic             r_dut_rst;
    logic [VEC_W-1:0] r_vec;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             w_clean;
    logic             w_accept;

    assign w_accept = (r_state == IDLE) & start & ~abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_rst_cnt <= '0;
            r_dut_rst <= 1'b0;
            r_vec     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state   <= IDLE;
                r_dut_rst <= 1'b0;
                r_vec     <= '0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_state   <= DUT_RST;
                            r_rst_cnt <= 4'd1;
                            r_dut_rst <= 1'b1;
                            r_vec     <= '0;
                            r_busy    <= 1'b1;
                            r_pass    <= 1'b0;
                        end
                    end
                    DUT_RST: begin
                        if (r_rst_cnt == RST_LAST) begin
                            r_state   <= SWEEP;
                            r_dut_rst <= 1'b0;
                        end else begin
                            r_rst_cnt <= r_rst_cnt + 1'b1;
                        end
                    end
                    SWEEP: begin
                        if (r_vec == VEC_LAST) begin
                            r_state <= DRAIN;
                        end else begin
                            r_vec <= r_vec + 1'b1;
                        end
                    end
                    DRAIN: begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_pass  <= w_clean;
                    end
                    DONE: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    sweep_checker #(.ERR_W(ERR_W)) u_checker (
        .clk               (clk),
        .rst               (rst),
        .i_sweep           (r_state == SWEEP),
        .i_clr             (w_accept),
        .i_abort           (abort),
        .i_vec             (r_vec),
        .i_o1              (o1),
        .i_o2              (o2),
        .o_err_cnt         (err_cnt),
        .o_first_err_valid (first_err_valid),
        .o_first_err_vec   (first_err_vec),
        .o_clean           (w_clean)
    );

    assign dut_rst = r_dut_rst;
    assign vec     = r_vec;
    assign busy    = r_busy;
    assign done    = r_done;
    assign pass    = r_pass;
endmodule

// File: tb/tb_mux_dec_sweep_ctrl.sv
// Bench for mux_dec_sweep_ctrl with a behavioural datapath and fault injection.
module tb_mux_dec_sweep_ctrl;
    import mux_dec_pkg::*;

    localparam int RST_CYCLES = 2;
    localparam int ERR_W      = 9;
    localparam int LATENCY    = RST_CYCLES + 257;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             dut_rst;
    logic [VEC_W-1:0] vec;
    logic             o1 = 1'b0;
    logic             o2 = 1'b0;
    logic             busy, done, pass;
    logic [ERR_W-1:0] err_cnt;
    logic             first_err_valid;
    logic [VEC_W-1:0] first_err_vec;

    int n_checks = 0;
    int n_errors = 0;

    // 0: correct, 1: o2 inverted at 8'h2A, 2: o1 stuck at 0, 3: o2 inverted on random mask
    int           fault_mode = 0;
    logic [255:0] fault_mask = '0;

    always #5 clk = ~clk;

    mux_dec_sweep_ctrl #(.RST_CYCLES(RST_CYCLES), .ERR_W(ERR_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .dut_rst         (dut_rst),
        .vec             (vec),
        .o1              (o1),
        .o2              (o2),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_cnt         (err_cnt),
        .first_err_valid (first_err_valid),
        .first_err_vec   (first_err_vec)
    );

    // 16:1 mux selected by a..d, xor'd with a 2:4 decoder (e,f) output picked by g,h.
    function automatic logic ref_out(input logic [7:0] v);
        logic [15:0] k;
        logic [3:0]  sel;
        logic [3:0]  dec;
        logic [1:0]  pick;
        k    = 16'hB5C3;
        sel  = {v[D_IDX], v[C_IDX], v[B_IDX], v[A_IDX]};
        dec  = 4'b0001 << {v[F_IDX], v[E_IDX]};
        pick = {v[H_IDX], v[G_IDX]};
        return k[sel] ^ dec[pick];
    endfunction

    function automatic bit mismatch_at(input int v);
        logic [7:0] b;
        b = 8'(v);
        case (fault_mode)
            1:       return (v == 'h2A);
            2:       return ref_out(b) == 1'b1;
            3:       return fault_mask[v] == 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (dut_rst) begin
            o1 <= 1'b0;
            o2 <= 1'b0;
        end else begin
            o1 <= (fault_mode == 2) ? 1'b0 : ref_out(vec);
            o2 <= ref_out(vec) ^ ((fault_mode == 1 && vec == 8'h2A) ||
                                  (fault_mode == 3 && fault_mask[vec] == 1'b1));
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_sweep(input string tag);
        int exp_cnt;
        int exp_first;
        int n;
        exp_cnt   = 0;
        exp_first = -1;
        for (int v = 0; v < NUM_VEC; v++) begin
            if (mismatch_at(v)) begin
                exp_cnt++;
                if (exp_first < 0) exp_first = v;
            end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_t0"}, 32'(busy), 32'd1);
        check({tag, "_dutrst_t0"}, 32'(dut_rst), 32'd1);
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            tick();
            n++;
            if (n == RST_CYCLES) begin
                check({tag, "_first_vec"}, 32'(vec), 32'd0);
                check({tag, "_dutrst_sweep"}, 32'(dut_rst), 32'd0);
            end
        end
        check({tag, "_latency"}, 32'(n), 32'(LATENCY));
        check({tag, "_pass"}, 32'(pass), 32'(exp_cnt == 0));
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_cnt));
        check({tag, "_fev"}, 32'(first_err_valid), 32'(exp_cnt != 0));
        check({tag, "_fevec"}, 32'(first_err_vec), 32'(exp_first < 0 ? 0 : exp_first));
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_pass_hold"}, 32'(pass), 32'(exp_cnt == 0));
    endtask

    task automatic wait_vec(input int target, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < 400) begin
            tick();
            n++;
            if (busy && !dut_rst && vec == 8'(target)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int n;
        int ndone;
        #2 rst = 1'b0;
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dut_rst", 32'(dut_rst), 32'd0);
        check("rst_vec", 32'(vec), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) tick();

        fault_mode = 0;
        run_sweep("clean");
        fault_mode = 1;
        run_sweep("one_err");
        fault_mode = 2;
        run_sweep("stuck0");

        // abort mid-sweep freezes results
        fault_mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_vec(100, ok);
        check("abort_reach_vec", 32'(ok), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_dut_rst", 32'(dut_rst), 32'd0);
        ndone = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        check("abort_err_frozen", 32'(err_cnt), 32'd1);
        check("abort_fevec", 32'(first_err_vec), 32'h2A);
        check("abort_pass", 32'(pass), 32'd0);
        fault_mode = 0;
        run_sweep("after_abort");

        // asynchronous reset mid-sweep
        fault_mode = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_vec(50, ok);
        check("arst_reach_vec", 32'(ok), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_vec", 32'(vec), 32'd0);
        check("arst_err_cnt", 32'(err_cnt), 32'd0);
        check("arst_fev", 32'(first_err_valid), 32'd0);
        check("arst_dut_rst", 32'(dut_rst), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        fault_mode = 3;
        fault_mask = {$urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom};
        run_sweep("after_arst");

        // start held high through the whole sweep and the done cycle
        fault_mode = 0;
        start = 1'b1;
        tick();
        n = 0;
        ndone = 0;
        while (done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check("spam_latency", 32'(n), 32'(LATENCY));
        tick();
        start = 1'b0;
        check("spam_busy_after_done", 32'(busy), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy || done) ndone++;
        end
        check("spam_no_restart", 32'(ndone), 32'd0);

        for (int r = 0; r < 2; r++) begin
            fault_mode = 3;
            fault_mask = '0;
            for (int i = 0; i < 6; i++) fault_mask[$urandom_range(255, 0)] = 1'b1;
            repeat ($urandom_range(7, 0)) tick();
            run_sweep("rand_sparse");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
